// File: rtl/cp0_irq_nest.sv
// MIPS-style coprocessor 0: Status/Cause/EPC, Count/Compare timer, hardware interrupt
// sampling and a bounded stack of {EPC, IE} so traps can nest up to NEST_DEPTH deep.
module cp0_irq_nest #(
    parameter int unsigned NUM_IRQ    = 5,
    parameter int unsigned NEST_DEPTH = 4,
    parameter int unsigned TIMER_DIV  = 1,
    parameter logic [31:0] EXC_BASE   = 32'h00400004
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mfc0,
    input  logic                                  mtc0,
    input  logic [4:0]                            addr,
    input  logic [31:0]                           wdata,
    input  logic [31:0]                           pc,
    input  logic                                  exception,
    input  logic [4:0]                            exc_code,
    input  logic                                  eret,
    input  logic [NUM_IRQ-1:0]                    irq,
    output logic [31:0]                           rdata,
    output logic [31:0]                           status,
    output logic [31:0]                           epc_out,
    output logic                                  trap_take,
    output logic [31:0]                           exc_vector,
    output logic [$clog2(NEST_DEPTH+1)-1:0]       nest_level,
    output logic                                  nest_ovf
);

    localparam int unsigned LW = $clog2(NEST_DEPTH + 1);
    localparam int unsigned IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam int unsigned DW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [LW-1:0] DEPTH    = LW'(NEST_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(TIMER_DIV - 1);

    localparam logic [4:0] R_COUNT   = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;
    localparam logic [4:0] R_STATUS  = 5'd12;
    localparam logic [4:0] R_CAUSE   = 5'd13;
    localparam logic [4:0] R_EPC     = 5'd14;

    logic [31:0]   count;
    logic [31:0]   compare;
    logic          ie;
    logic [7:0]    im;
    logic [6:0]    ip_hw;
    logic          ip_tmr;
    logic [4:0]    exc_code_q;
    logic [31:0]   epc;
    logic          ovf;
    logic [LW-1:0] level;
    logic [DW-1:0] div_cnt;
    logic [31:0]   epc_stk [NEST_DEPTH];
    logic [NEST_DEPTH-1:0] ie_stk;

    logic [7:0]    ip;
    logic          int_req;
    logic          wr;
    logic          wr_count;
    logic          wr_compare;
    logic          wr_status;
    logic          wr_cause;
    logic          wr_epc;
    logic          tick;
    logic [31:0]   count_inc;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;
    logic [31:0]   cause;
    logic          unused_wdata;

    assign ip        = {ip_tmr, ip_hw};
    assign int_req   = ie & |(ip & im);
    assign trap_take = (exception | int_req) & ~eret & (level < DEPTH);

    // A trap, an eret or a dropped exception all outrank a coincident register write.
    assign wr         = mtc0 & ~eret & ~exception & ~trap_take;
    assign wr_count   = wr & (addr == R_COUNT);
    assign wr_compare = wr & (addr == R_COMPARE);
    assign wr_status  = wr & (addr == R_STATUS);
    assign wr_cause   = wr & (addr == R_CAUSE);
    assign wr_epc     = wr & (addr == R_EPC);

    assign tick      = (div_cnt == DIV_LAST);
    assign count_inc = count + 32'd1;
    assign push_idx  = IW'(level);
    assign pop_idx   = IW'(level - LW'(1));

    assign status       = {16'h0000, im, 7'h00, ie};
    assign cause        = {16'h0000, ip, 1'b0, exc_code_q, 2'b00};
    assign epc_out      = epc;
    assign exc_vector   = EXC_BASE;
    assign nest_level   = level;
    assign nest_ovf     = ovf;
    assign unused_wdata = ^{wdata[30:16], wdata[7], wdata[1]};

    always_comb begin
        rdata = 32'h0;
        if (mfc0) begin
            case (addr)
                R_COUNT:   rdata = count;
                R_COMPARE: rdata = compare;
                R_STATUS:  rdata = status;
                R_CAUSE:   rdata = cause;
                R_EPC:     rdata = epc;
                default:   rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 32'h0;
            compare    <= 32'hFFFF_FFFF;
            ie         <= 1'b1;
            im         <= 8'hFF;
            ip_hw      <= 7'h00;
            ip_tmr     <= 1'b0;
            exc_code_q <= 5'd0;
            epc        <= 32'h0;
            ovf        <= 1'b0;
            level      <= '0;
            div_cnt    <= '0;
            ie_stk     <= '0;
            for (int i = 0; i < int'(NEST_DEPTH); i++) begin
                epc_stk[i] <= 32'h0;
            end
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            ip_hw   <= 7'(irq);

            // Timer: a Count write replaces this cycle's increment; a Compare write acks IP[15].
            if (wr_count) begin
                count <= wdata;
            end else if (tick) begin
                count <= count_inc;
            end
            if (wr_compare) begin
                compare <= wdata;
                ip_tmr  <= 1'b0;
            end else if (tick && !wr_count && count_inc == compare) begin
                ip_tmr <= 1'b1;
            end

            if (eret) begin
                if (level != '0) begin
                    epc   <= epc_stk[pop_idx];
                    ie    <= ie_stk[pop_idx];
                    level <= level - LW'(1);
                end
            end else if (trap_take) begin
                epc_stk[push_idx] <= epc;
                ie_stk[push_idx]  <= ie;
                epc               <= pc;
                ie                <= 1'b0;
                exc_code_q        <= exception ? exc_code : 5'd0;
                level             <= level + LW'(1);
            end else begin
                if (exception) begin
                    ovf <= 1'b1;
                end
                if (wr_status) begin
                    ie <= wdata[0];
                    im <= wdata[15:8];
                    if (wdata[31]) begin
                        ovf <= 1'b0;
                    end
                end
                if (wr_cause) begin
                    exc_code_q <= wdata[6:2];
                end
                if (wr_epc) begin
                    epc <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_irq_nest.sv
// Bench for cp0_irq_nest: directed scenarios plus random traffic against a queue-based model.
module tb_cp0_irq_nest;

    localparam int unsigned NUM_IRQ    = 5;
    localparam int unsigned NEST_DEPTH = 4;
    localparam int unsigned TIMER_DIV  = 1;
    localparam int unsigned LW         = $clog2(NEST_DEPTH + 1);

    logic               clk;
    logic               rst;
    logic               mfc0;
    logic               mtc0;
    logic [4:0]         addr;
    logic [31:0]        wdata;
    logic [31:0]        pc;
    logic               exception;
    logic [4:0]         exc_code;
    logic               eret;
    logic [NUM_IRQ-1:0] irq;
    logic [31:0]        rdata;
    logic [31:0]        status;
    logic [31:0]        epc_out;
    logic               trap_take;
    logic [31:0]        exc_vector;
    logic [LW-1:0]      nest_level;
    logic               nest_ovf;

    int n_checks;
    int n_fail;

    cp0_irq_nest #(
        .NUM_IRQ   (NUM_IRQ),
        .NEST_DEPTH(NEST_DEPTH),
        .TIMER_DIV (TIMER_DIV),
        .EXC_BASE  (32'h00400004)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mfc0      (mfc0),
        .mtc0      (mtc0),
        .addr      (addr),
        .wdata     (wdata),
        .pc        (pc),
        .exception (exception),
        .exc_code  (exc_code),
        .eret      (eret),
        .irq       (irq),
        .rdata     (rdata),
        .status    (status),
        .epc_out   (epc_out),
        .trap_take (trap_take),
        .exc_vector(exc_vector),
        .nest_level(nest_level),
        .nest_ovf  (nest_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural registers plus a LIFO of saved {EPC, IE}.
    logic [31:0] m_count, m_compare, m_epc;
    logic        m_ie, m_ip15, m_ovf;
    logic [7:0]  m_im;
    logic [6:0]  m_iphw;
    logic [4:0]  m_exc;
    int          m_div;
    logic [31:0] q_epc[$];
    logic        q_ie[$];

    function automatic logic [31:0] m_status();
        return {16'h0, m_im, 7'h0, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {16'h0, m_ip15, m_iphw, 1'b0, m_exc, 2'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_take();
        logic pending;
        pending = m_ie && (({m_ip15, m_iphw} & m_im) != 8'h0);
        return (exception || pending) && !eret && (q_epc.size() < int'(NEST_DEPTH));
    endfunction

    task automatic model_reset();
        m_count = 32'h0; m_compare = 32'hFFFFFFFF; m_epc = 32'h0;
        m_ie = 1'b1; m_im = 8'hFF; m_ip15 = 1'b0; m_iphw = 7'h0;
        m_exc = 5'd0; m_ovf = 1'b0; m_div = 0;
        q_epc.delete(); q_ie.delete();
    endtask

    task automatic model_step();
        logic take, wr, tick;
        if (rst) begin
            model_reset();
            return;
        end
        take = m_take();
        wr   = mtc0 && !eret && !exception && !take;
        tick = (m_div == int'(TIMER_DIV) - 1);
        m_div = tick ? 0 : m_div + 1;
        if (tick && !(wr && addr == 5'd9)) begin
            m_count = m_count + 32'd1;
            if (m_count == m_compare) m_ip15 = 1'b1;
        end
        if (wr && addr == 5'd9) m_count = wdata;
        if (wr && addr == 5'd11) begin
            m_compare = wdata;
            m_ip15    = 1'b0;
        end
        m_iphw = 7'(irq);
        if (eret) begin
            if (q_epc.size() > 0) begin
                m_epc = q_epc.pop_back();
                m_ie  = q_ie.pop_back();
            end
        end else if (take) begin
            q_epc.push_back(m_epc);
            q_ie.push_back(m_ie);
            m_epc = pc;
            m_ie  = 1'b0;
            m_exc = exception ? exc_code : 5'd0;
        end else if (exception) begin
            m_ovf = 1'b1;
        end
        if (wr && addr == 5'd12) begin
            m_ie = wdata[0];
            m_im = wdata[15:8];
            if (wdata[31]) m_ovf = 1'b0;
        end
        if (wr && addr == 5'd13) m_exc = wdata[6:2];
        if (wr && addr == 5'd14) m_epc = wdata;
    endtask

    task automatic idle_inputs();
        mfc0 = 1'b0; mtc0 = 1'b0; addr = 5'd0; wdata = 32'h0; pc = 32'h0;
        exception = 1'b0; exc_code = 5'd0; eret = 1'b0; irq = '0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        mfc0 = 1'b1; addr = 5'd11;
        #1;
        n_checks++; if (status !== 32'h0000FF01) begin n_fail++; $display("FAIL reset_status got %h want %h", status, 32'h0000FF01); end
        n_checks++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want 0", epc_out); end
        n_checks++; if (nest_level !== LW'(0)) begin n_fail++; $display("FAIL reset_nest got %0d want 0", nest_level); end
        n_checks++; if (nest_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", nest_ovf); end
        n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_compare got %h want ffffffff", rdata); end
        n_checks++; if (exc_vector !== 32'h00400004) begin n_fail++; $display("FAIL exc_vector got %h want 00400004", exc_vector); end
        idle_inputs();
    endtask

    task automatic test_nested_exceptions();
        idle_inputs();
        exception = 1'b1; exc_code = 5'd8; pc = 32'h00400100;
        #1;
        n_checks++; if (trap_take !== 1'b1) begin n_fail++; $display("FAIL nest_take1 got %b want 1", trap_take); end
        cycle();
        idle_inputs();
        mfc0 = 1'b1; addr = 5'd13;
        #1;
        n_checks++; if (epc_out !== 32'h00400100) begin n_fail++; $display("FAIL nest_epc1 got %h want 00400100", epc_out); end
        n_checks++; if (status[0] !== 1'b0) begin n_fail++; $display("FAIL nest_ie1 got %b want 0", status[0]); end
        n_checks++; if (rdata[6:2] !== 5'd8) begin n_fail++; $display("FAIL nest_exccode got %0d want 8", rdata[6:2]); end
        n_checks++; if (nest_level !== LW'(1)) begin n_fail++; $display("FAIL nest_level1 got %0d want 1", nest_level); end
        idle_inputs();
        exception = 1'b1; exc_code = 5'd8; pc = 32'h00400200;
        cycle();
        idle_inputs();
        n_checks++; if (nest_level !== LW'(2)) begin n_fail++; $display("FAIL nest_level2 got %0d want 2", nest_level); end
        n_checks++; if (epc_out !== 32'h00400200) begin n_fail++; $display("FAIL nest_epc2 got %h want 00400200", epc_out); end
        eret = 1'b1;
        cycle();
        n_checks++; if (epc_out !== 32'h00400100) begin n_fail++; $display("FAIL eret1_epc got %h want 00400100", epc_out); end
        n_checks++; if (nest_level !== LW'(1)) begin n_fail++; $display("FAIL eret1_nest got %0d want 1", nest_level); end
        cycle();
        eret = 1'b0;
        n_checks++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL eret2_epc got %h want 0", epc_out); end
        n_checks++; if (status !== 32'h0000FF01) begin n_fail++; $display("FAIL eret2_status got %h want 0000ff01", status); end
        n_checks++; if (nest_level !== LW'(0)) begin n_fail++; $display("FAIL eret2_nest got %0d want 0", nest_level); end
    endtask

    task automatic test_timer();
        idle_inputs();
        mtc0 = 1'b1; addr = 5'd9; wdata = 32'd0;
        cycle();
        addr = 5'd11; wdata = 32'd5;
        cycle();
        idle_inputs();
        repeat (3) cycle();
        mfc0 = 1'b1; addr = 5'd13;
        #1;
        n_checks++; if (rdata[15] !== 1'b0) begin n_fail++; $display("FAIL timer_early got %b want 0", rdata[15]); end
        cycle();
        n_checks++; if (rdata[15] !== 1'b1) begin n_fail++; $display("FAIL timer_ip15 got %b want 1", rdata[15]); end
        n_checks++; if (trap_take !== 1'b1) begin n_fail++; $display("FAIL timer_take got %b want 1", trap_take); end
        cycle();
        n_checks++; if (rdata[6:2] !== 5'd0) begin n_fail++; $display("FAIL timer_exccode got %0d want 0", rdata[6:2]); end
        n_checks++; if (nest_level !== LW'(1)) begin n_fail++; $display("FAIL timer_nest got %0d want 1", nest_level); end
        idle_inputs();
        mtc0 = 1'b1; addr = 5'd11; wdata = 32'hFFFFFFFF;
        cycle();
        idle_inputs();
        mfc0 = 1'b1; addr = 5'd13;
        #1;
        n_checks++; if (rdata[15] !== 1'b0) begin n_fail++; $display("FAIL timer_ack got %b want 0", rdata[15]); end
        idle_inputs();
        eret = 1'b1;
        cycle();
        idle_inputs();
        n_checks++; if (nest_level !== LW'(0)) begin n_fail++; $display("FAIL timer_eret got %0d want 0", nest_level); end
    endtask

    task automatic test_irq_mask();
        idle_inputs();
        mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0000FE01;
        cycle();
        idle_inputs();
        irq = NUM_IRQ'(1);
        cycle();
        mfc0 = 1'b1; addr = 5'd13;
        #1;
        n_checks++; if (rdata[8] !== 1'b1) begin n_fail++; $display("FAIL irq_ip8 got %b want 1", rdata[8]); end
        n_checks++; if (trap_take !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b want 0", trap_take); end
        mfc0 = 1'b0;
        mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0000FF01;
        #1;
        n_checks++; if (trap_take !== 1'b0) begin n_fail++; $display("FAIL irq_unmask_cycle got %b want 0", trap_take); end
        cycle();
        mtc0 = 1'b0; addr = 5'd0; wdata = 32'h0;
        #1;
        n_checks++; if (trap_take !== 1'b1) begin n_fail++; $display("FAIL irq_take got %b want 1", trap_take); end
        cycle();
        n_checks++; if (nest_level !== LW'(1)) begin n_fail++; $display("FAIL irq_nest got %0d want 1", nest_level); end
        n_checks++; if (status !== 32'h0000FF00) begin n_fail++; $display("FAIL irq_status got %h want 0000ff00", status); end
        irq = '0;
        cycle();
        eret = 1'b1;
        cycle();
        idle_inputs();
        n_checks++; if (status !== 32'h0000FF01) begin n_fail++; $display("FAIL irq_eret_status got %h want 0000ff01", status); end
    endtask

    task automatic test_overflow();
        logic [31:0] base_epc;
        base_epc = m_epc;
        idle_inputs();
        for (int i = 0; i <= int'(NEST_DEPTH); i++) begin
            exception = 1'b1; exc_code = 5'(i + 1); pc = 32'h00400300 + 32'(16 * i);
            #1;
            n_checks++; if (trap_take !== (i < int'(NEST_DEPTH))) begin n_fail++; $display("FAIL ovf_take%0d got %b want %b", i, trap_take, (i < int'(NEST_DEPTH))); end
            cycle();
        end
        idle_inputs();
        mfc0 = 1'b1; addr = 5'd13;
        #1;
        n_checks++; if (nest_level !== LW'(NEST_DEPTH)) begin n_fail++; $display("FAIL ovf_nest got %0d want %0d", nest_level, NEST_DEPTH); end
        n_checks++; if (nest_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", nest_ovf); end
        n_checks++; if (epc_out !== 32'h00400300 + 32'(16 * (NEST_DEPTH - 1))) begin n_fail++; $display("FAIL ovf_epc got %h", epc_out); end
        n_checks++; if (rdata[6:2] !== 5'(NEST_DEPTH)) begin n_fail++; $display("FAIL ovf_exccode got %0d want %0d", rdata[6:2], NEST_DEPTH); end
        idle_inputs();
        mtc0 = 1'b1; addr = 5'd12; wdata = 32'h8000FF00;
        cycle();
        idle_inputs();
        n_checks++; if (nest_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", nest_ovf); end
        n_checks++; if (status !== 32'h0000FF00) begin n_fail++; $display("FAIL ovf_status got %h want 0000ff00", status); end
        eret = 1'b1;
        repeat (NEST_DEPTH) cycle();
        idle_inputs();
        n_checks++; if (nest_level !== LW'(0)) begin n_fail++; $display("FAIL ovf_unwind got %0d want 0", nest_level); end
        n_checks++; if (epc_out !== base_epc) begin n_fail++; $display("FAIL ovf_unwind_epc got %h want %h", epc_out, base_epc); end
        n_checks++; if (status !== 32'h0000FF01) begin n_fail++; $display("FAIL ovf_unwind_status got %h want 0000ff01", status); end
    endtask

    task automatic test_eret_empty();
        logic [31:0] s, e;
        s = m_status();
        e = m_epc;
        idle_inputs();
        eret = 1'b1;
        cycle();
        idle_inputs();
        n_checks++; if (status !== s) begin n_fail++; $display("FAIL eret0_status got %h want %h", status, s); end
        n_checks++; if (epc_out !== e) begin n_fail++; $display("FAIL eret0_epc got %h want %h", epc_out, e); end
        n_checks++; if (nest_level !== LW'(0)) begin n_fail++; $display("FAIL eret0_nest got %0d want 0", nest_level); end
    endtask

    task automatic test_exc_eret_same();
        logic [31:0] e;
        e = m_epc;
        idle_inputs();
        exception = 1'b1; exc_code = 5'd9; pc = 32'h00400500;
        cycle();
        pc = 32'h00400600; eret = 1'b1;
        #1;
        n_checks++; if (trap_take !== 1'b0) begin n_fail++; $display("FAIL same_take got %b want 0", trap_take); end
        cycle();
        idle_inputs();
        n_checks++; if (nest_level !== LW'(0)) begin n_fail++; $display("FAIL same_nest got %0d want 0", nest_level); end
        n_checks++; if (epc_out !== e) begin n_fail++; $display("FAIL same_epc got %h want %h", epc_out, e); end
        n_checks++; if (status !== 32'h0000FF01) begin n_fail++; $display("FAIL same_status got %h want 0000ff01", status); end
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            exception = ($urandom_range(0, 7) == 0);
            exc_code  = 5'($urandom);
            eret      = ($urandom_range(0, 6) == 0);
            irq       = ($urandom_range(0, 3) == 0) ? NUM_IRQ'($urandom) : irq;
            pc        = $urandom & 32'hFFFFFFFC;
            mfc0      = $urandom_range(0, 1) == 1;
            mtc0      = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0: addr = 5'd9;
                1: addr = 5'd11;
                2: addr = 5'd12;
                3: addr = 5'd13;
                4: addr = 5'd14;
                default: addr = 5'($urandom);
            endcase
            wdata = $urandom;
            if (addr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + 32'($urandom_range(1, 6));
            if (addr == 5'd12 && $urandom_range(0, 1) == 1) wdata = wdata & 32'h8000FF00;
            #1;
            exp_rd = mfc0 ? m_read(addr) : 32'h0;
            n_checks++; if (trap_take !== m_take()) begin n_fail++; $display("FAIL rnd_take cyc %0d got %b want %b", n, trap_take, m_take()); end
            n_checks++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata cyc %0d addr %0d got %h want %h", n, addr, rdata, exp_rd); end
            cycle();
            n_checks++; if (status !== m_status()) begin n_fail++; $display("FAIL rnd_status cyc %0d got %h want %h", n, status, m_status()); end
            n_checks++; if (epc_out !== m_epc) begin n_fail++; $display("FAIL rnd_epc cyc %0d got %h want %h", n, epc_out, m_epc); end
            n_checks++; if (nest_level !== LW'(q_epc.size())) begin n_fail++; $display("FAIL rnd_nest cyc %0d got %0d want %0d", n, nest_level, q_epc.size()); end
            n_checks++; if (nest_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %b want %b", n, nest_ovf, m_ovf); end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_nested_exceptions();
        test_timer();
        test_irq_mask();
        test_overflow();
        test_eret_empty();
        test_exc_eret_same();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
